// File: rtl/parity_checker.sv
// Receive-side parity checker: recomputes parity, forwards each word through a one-deep
// output stage with an error tag, and keeps sticky error status (counter via PARITY_CHECKER_ERR_CNT_EN).
module parity_checker #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned PARITY_TYPE = 0,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  parity_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  parity_err_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  err_clr,
    output logic                  err_flag,
    output logic [CNT_WIDTH-1:0]  err_count
);

    localparam logic LP_ODD = (PARITY_TYPE != 0);

    logic                  w_expected;
    logic                  w_err;
    logic                  w_accept;
    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_perr;
    logic                  r_valid;
    logic                  r_flag;

    assign w_expected = (^data_in) ^ LP_ODD;
    assign w_err      = (parity_in != w_expected);
    assign in_ready   = !r_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_xfer     = r_valid && out_ready;

    // Data and tag load only on accept, so they hold through stalls and after drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_perr  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data  <= data_in;
                r_perr  <= w_err;
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Status follows accept; an errored accept wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= 1'b0;
        end else if (w_accept && w_err) begin
            r_flag <= 1'b1;
        end else if (err_clr) begin
            r_flag <= 1'b0;
        end
    end

`ifdef PARITY_CHECKER_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_accept && w_err) begin
            if (err_clr) begin
                r_count <= CNT_WIDTH'(1);
            end else if (r_count != '1) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
        end else if (err_clr) begin
            r_count <= '0;
        end
    end

    assign err_count = r_count;
`else
    assign err_count = '0;
`endif

    assign data_out       = r_data;
    assign parity_err_out = r_perr;
    assign out_valid      = r_valid;
    assign err_flag       = r_flag;

endmodule

// File: tb/tb_parity_checker.sv
// Scoreboard bench for parity_checker: driver pushes expected {err,data} on accept,
// monitor compares the held output every valid cycle and pops on transfer.
module tb_parity_checker;

`ifdef PARITY_CHECKER_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic        parity_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_out;
    logic        parity_err_out;
    logic        out_valid;
    logic        out_ready;
    logic        err_clr;
    logic        err_flag;
    logic [1:0]  err_count;

    logic [7:0]  o_data;
    logic        o_par;
    logic        o_valid;
    logic        o_in_ready;
    logic [7:0]  o_dout;
    logic        o_perr;
    logic        o_out_valid;
    logic        o_flag;
    logic [3:0]  o_count;

    int checks = 0;
    int errors = 0;
    logic [32:0] sb[$];

    parity_checker #(.DATA_WIDTH(32), .PARITY_TYPE(0), .CNT_WIDTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .parity_in(parity_in),
        .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out),
        .parity_err_out(parity_err_out), .out_valid(out_valid), .out_ready(out_ready),
        .err_clr(err_clr), .err_flag(err_flag), .err_count(err_count)
    );

    parity_checker #(.DATA_WIDTH(8), .PARITY_TYPE(1), .CNT_WIDTH(4)) u_odd (
        .clk(clk), .rst_n(rst_n), .data_in(o_data), .parity_in(o_par),
        .in_valid(o_valid), .in_ready(o_in_ready), .data_out(o_dout),
        .parity_err_out(o_perr), .out_valid(o_out_valid), .out_ready(1'b1),
        .err_clr(1'b0), .err_flag(o_flag), .err_count(o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] ecnt(input int v);
        return CNT_ON ? 2'(v) : 2'd0;
    endfunction

    task automatic send(input logic [31:0] d, input logic p, input logic e, input logic clr);
        int n;
        @(negedge clk);
        data_in = d; parity_in = p; in_valid = 1'b1; err_clr = clr;
        n = 0;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept_within_20");
            in_valid = 1'b0;
            err_clr = 1'b0;
        end else begin
            sb.push_back({e, d});
            @(posedge clk);
            #1;
            err_clr = 1'b0;
            chk("latency_out_valid", 33'(out_valid), 33'd1);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        data_in = '0;
        parity_in = 1'b0;
    endtask

    task automatic clear_status();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    // Monitor: held output must match the scoreboard head every valid cycle.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h required=no_output", data_out);
                end else begin
                    chk("out_word", {parity_err_out, data_out}, sb[0]);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; data_in = '0; parity_in = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; err_clr = 1'b0;
        o_data = '0; o_par = 1'b0; o_valid = 1'b0;
        #12;
        chk("rst_out_valid", 33'(out_valid), 33'd0);
        chk("rst_data_out", 33'(data_out), 33'd0);
        chk("rst_perr", 33'(parity_err_out), 33'd0);
        chk("rst_err_flag", 33'(err_flag), 33'd0);
        chk("rst_err_count", 33'(err_count), 33'd0);
        chk("rst_in_ready", 33'(in_ready), 33'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Good and bad parity on the same word.
        send(32'h0000_0001, 1'b1, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("good_err_flag", 33'(err_flag), 33'd0);
        send(32'h0000_0001, 1'b0, 1'b1, 1'b0);
        idle();
        chk("bad_err_flag", 33'(err_flag), 33'd1);
        chk("bad_err_count", 33'(err_count), 33'(ecnt(1)));
        clear_status();
        chk("clr_err_flag", 33'(err_flag), 33'd0);
        chk("clr_err_count", 33'(err_count), 33'd0);

        // Back-to-back words at full rate.
        send(32'h0000_00A5, 1'b0, 1'b0, 1'b0);
        send(32'h0000_00A4, 1'b0, 1'b1, 1'b0);
        send(32'h0000_0000, 1'b0, 1'b0, 1'b0);
        idle();
        chk("b2b_err_count", 33'(err_count), 33'(ecnt(1)));
        chk("b2b_err_flag", 33'(err_flag), 33'd1);
        clear_status();

        // Stall three cycles with an errored word held and the next word pending.
        send(32'h0000_0003, 1'b1, 1'b1, 1'b0);
        fork
            send(32'h0000_0007, 1'b1, 1'b0, 1'b0);
            begin
                @(negedge clk);
                out_ready = 1'b0;
                repeat (3) begin
                    #1;
                    chk("stall_in_ready", 33'(in_ready), 33'd0);
                    chk("stall_err_count", 33'(err_count), 33'(ecnt(1)));
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        idle();
        @(negedge clk);
        chk("post_stall_err_count", 33'(err_count), 33'(ecnt(1)));
        clear_status();

        // Saturation, then clear coinciding with an errored accept.
        repeat (5) send(32'h0000_0001, 1'b0, 1'b1, 1'b0);
        idle();
        chk("sat_err_count", 33'(err_count), 33'(ecnt(3)));
        send(32'h0000_0001, 1'b0, 1'b1, 1'b1);
        idle();
        chk("clr_vs_err_count", 33'(err_count), 33'(ecnt(1)));
        chk("clr_vs_err_flag", 33'(err_flag), 33'd1);

        // Asynchronous reset while a word is held.
        @(negedge clk);
        out_ready = 1'b0;
        send(32'h0000_0001, 1'b0, 1'b1, 1'b0);
        idle();
        chk("pre_rst_out_valid", 33'(out_valid), 33'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 33'(out_valid), 33'd0);
        chk("arst_err_flag", 33'(err_flag), 33'd0);
        chk("arst_err_count", 33'(err_count), 33'd0);
        chk("arst_data_out", 33'(data_out), 33'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Odd-parity instance.
        @(negedge clk);
        o_data = 8'h01; o_par = 1'b0; o_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("odd_out_valid", 33'(o_out_valid), 33'd1);
        chk("odd_good_perr", 33'(o_perr), 33'd0);
        chk("odd_data_out", 33'(o_dout), 33'h01);
        @(negedge clk);
        o_par = 1'b1;
        @(posedge clk);
        #1;
        chk("odd_bad_perr", 33'(o_perr), 33'd1);
        chk("odd_err_flag", 33'(o_flag), 33'd1);
        @(negedge clk);
        o_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("sb_drained", 33'(sb.size()), 33'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_checker.md
Name: parity_checker

Overview:
- Receive-side partner of the parity generator.
- Accepts a data word plus its parity bit over a valid/ready stream and recomputes parity. Forwards the word downstream through a one-deep output register, tagged with a per-word error bit.
- Keeps a sticky error flag and an optional saturating error counter for status readback.
- Sits at the sink end of any link protected by the parity generator.

Parameters:
- DATA_WIDTH, 32, width of the protected data word.
- PARITY_TYPE, 0, 0 = even parity, 1 = odd parity. Must match the transmitting generator.
- CNT_WIDTH, 16, width of the error counter (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  DATA_WIDTH  received data word.
- parity_in  input  1  received parity bit.
- in_valid  input  1  data_in/parity_in valid.
- in_ready  output  1  checker can accept a word this cycle.
- data_out  output  DATA_WIDTH  registered copy of the accepted word.
- parity_err_out  output  1  registered error tag for data_out.
- out_valid  output  1  data_out/parity_err_out valid.
- out_ready  input  1  downstream accepts the output word.
- err_clr  input  1  synchronous clear of err_flag and err_count.
- err_flag  output  1  sticky: at least one parity error accepted since reset or clear.
- err_count  output  CNT_WIDTH  number of errored words accepted, saturating.

Behaviour:
- Reset (rst_n low, asynchronous) sets out_valid=0, data_out=0, parity_err_out=0, err_flag=0 and err_count=0. After reset, in_ready=1 combinationally, because out_valid=0. Reset mid-transfer discards the held word without signalling.
- Expected parity: expected = (^data_in) XOR PARITY_TYPE. Even: expected = XOR of the data bits. Odd: expected = the inverted XOR.
- Error detection: err = (parity_in != expected), evaluated combinationally on the input.
- in_ready = !out_valid || out_ready. The output register is a pipeline stage, so full throughput of one word per clock is supported.
- Accept: in_valid && in_ready. On the next edge: data_out <= data_in, parity_err_out <= err, out_valid <= 1.
- Output transfer: out_valid && out_ready. If there is no simultaneous accept, out_valid <= 0 on the next edge. data_out and parity_err_out hold their last value.
- Simultaneous output transfer and input accept: the register reloads with the new word and out_valid stays 1. There is no bubble.
- Stall: out_valid && !out_ready forces in_ready=0. data_out and parity_err_out must stay stable until transfer.
- Latency: one clock from accept to out_valid.
- err_flag:
  - Set on the edge after an accepted word with err=1.
  - Cleared by err_clr.
  - Simultaneous err_clr and errored accept: set wins, so err_flag=1.
- Status updates are tied to accept, not to output transfer. An errored word counts once even if it stalls in the output register.
- in_valid without in_ready: the word is not sampled. Status is not updated, and upstream must hold the word.
- No X propagation: data_in is sampled only on accept.

Optional Feature:
- Macro PARITY_CHECKER_ERR_CNT_EN.
- Defined:
  - err_count increments by 1 on each accepted word with err=1.
  - It saturates at 2^CNT_WIDTH-1 and never wraps.
  - err_clr resets it to 0.
  - Simultaneous err_clr and errored accept: err_count = 1.
- Undefined: no counter logic is built and err_count is tied to 0. All other behaviour is identical.

Test Plan:
- Reset, then stream data_in=32'h0000_0001 with parity_in=1 and PARITY_TYPE=0 -> out_valid one cycle later, data_out=32'h0000_0001, parity_err_out=0, err_flag=0.
- Same word with parity_in=0 -> parity_err_out=1, err_flag=1, err_count=1 (macro on) or 0 (macro off). With PARITY_TYPE=1 the same word with parity_in=0 gives parity_err_out=0.
- Back-to-back words 8'hA5,p=0 / 8'hA4,p=0 / 8'h00,p=0 (DATA_WIDTH=8, even) with out_ready=1 -> one word per clock, tags 0,1,0, err_count=1.
- Hold out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, data_out stable, the errored word is counted once, and the pending input is accepted on the cycle out_ready returns.
- CNT_WIDTH=2, five errored words -> err_count stops at 3. Assert err_clr in the same cycle as a sixth errored accept -> err_count=1, err_flag=1.
- Assert rst_n low while out_valid=1 and err_flag=1 -> out_valid, err_flag and err_count go to 0 immediately, without waiting for a clock edge.
